// File: rtl/sevseg_pkg.sv
// Shared types and glyph table for the seven-segment display bank.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package sevseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t GLYPH_0 = 7'b1000000;
    localparam seg_t GLYPH_1 = 7'b1111001;
    localparam seg_t GLYPH_2 = 7'b0100100;
    localparam seg_t GLYPH_3 = 7'b0110000;
    localparam seg_t GLYPH_4 = 7'b0011001;
    localparam seg_t GLYPH_5 = 7'b0010010;
    localparam seg_t GLYPH_6 = 7'b0000010;
    localparam seg_t GLYPH_7 = 7'b1111000;
    localparam seg_t GLYPH_8 = 7'b0000000;
    localparam seg_t GLYPH_9 = 7'b0010000;
    localparam seg_t GLYPH_A = 7'b0001000;
    localparam seg_t GLYPH_B = 7'b0000011;
    localparam seg_t GLYPH_C = 7'b1000110;
    localparam seg_t GLYPH_D = 7'b0100001;
    localparam seg_t GLYPH_E = 7'b0000110;
    localparam seg_t GLYPH_F = 7'b0001110;

endpackage

// File: rtl/sevseg_hex_decode.sv
// Combinational hex-to-segment decoder with a blank override.
module sevseg_hex_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] num,
    input  logic       blank,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            unique case (num)
                4'h0: seg = GLYPH_0;
                4'h1: seg = GLYPH_1;
                4'h2: seg = GLYPH_2;
                4'h3: seg = GLYPH_3;
                4'h4: seg = GLYPH_4;
                4'h5: seg = GLYPH_5;
                4'h6: seg = GLYPH_6;
                4'h7: seg = GLYPH_7;
                4'h8: seg = GLYPH_8;
                4'h9: seg = GLYPH_9;
                4'hA: seg = GLYPH_A;
                4'hB: seg = GLYPH_B;
                4'hC: seg = GLYPH_C;
                4'hD: seg = GLYPH_D;
                4'hE: seg = GLYPH_E;
                4'hF: seg = GLYPH_F;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sevseg_digit_bank.sv
// N-digit display bank: digit storage with positional/shift entry, anode scan,
// blink and decimal point, with an/seg/dp registered together.
module sevseg_digit_bank
    import sevseg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_CYCLES  = 100000,
    parameter int BLINK_CYCLES = 25000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic                      shift_mode,
    input  logic [$clog2(DIGITS)-1:0] wr_pos,
    input  logic [3:0]                wr_num,
    input  logic                      clr,
    input  logic [DIGITS-1:0]         blink_mask,
    input  logic                      dp_en,
    input  logic [$clog2(DIGITS)-1:0] dp_pos,
    output logic [DIGITS-1:0]         an,
    output seg_t                      seg,
    output logic                      dp
);

    localparam int IW = $clog2(DIGITS);
    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int BW = $clog2(BLINK_CYCLES);

    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic [3:0]        val_q [DIGITS];
    logic [DIGITS-1:0] vld_q;
    logic [SW-1:0]     scan_cnt;
    logic [IW-1:0]     scan_idx;
    logic [BW-1:0]     blink_cnt;
    logic              blink_phase;

    logic [3:0] cur_val;
    logic       cur_vld;
    logic       cur_blink;
    logic       cur_blank;
    seg_t       seg_next;

    // Positions at or beyond DIGITS match no entry, so such writes fall through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) val_q[i] <= '0;
            vld_q <= '0;
        end else if (clr) begin
            for (int i = 0; i < DIGITS; i++) val_q[i] <= '0;
            vld_q <= '0;
        end else if (wr_en) begin
            if (shift_mode) begin
                for (int i = DIGITS - 1; i > 0; i--) val_q[i] <= val_q[i-1];
                val_q[0] <= wr_num;
                vld_q    <= {vld_q[DIGITS-2:0], 1'b1};
            end else begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (wr_pos == IW'(i)) begin
                        val_q[i] <= wr_num;
                        vld_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        cur_val   = '0;
        cur_vld   = 1'b0;
        cur_blink = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx == IW'(i)) begin
                cur_val   = val_q[i];
                cur_vld   = vld_q[i];
                cur_blink = blink_mask[i];
            end
        end
        cur_blank = !cur_vld || (blink_phase && cur_blink);
    end

    sevseg_hex_decode u_dec (
        .num   (cur_val),
        .blank (cur_blank),
        .seg   (seg_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~({{(DIGITS-1){1'b0}}, 1'b1} << scan_idx);
            seg <= seg_next;
            dp  <= !(dp_en && (dp_pos == scan_idx));
        end
    end

endmodule

// File: tb/tb_sevseg_digit_bank.sv
// Self-checking bench: a 4-digit and a 3-digit bank share stimulus and are
// compared every cycle against a cycle-count based reference model.
module tb_sevseg_digit_bank;

    localparam int S = 4;
    localparam int B = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, shift_mode, clr, dp_en;
    logic [1:0] wr_pos, dp_pos;
    logic [3:0] wr_num;
    logic [3:0] blink_a;
    logic [2:0] blink_b;
    logic [3:0] an_a;
    logic [2:0] an_b;
    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;

    int checks = 0;
    int errors = 0;

    int         n;
    int         mval [2][8];
    bit         mvld [2][8];
    int         nd   [2] = '{4, 3};
    logic [7:0] exp_an  [2];
    logic [6:0] exp_seg [2];
    logic       exp_dp  [2];

    always #5 clk = ~clk;

    sevseg_digit_bank #(.DIGITS(4), .SCAN_CYCLES(S), .BLINK_CYCLES(B)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .shift_mode(shift_mode),
        .wr_pos(wr_pos), .wr_num(wr_num), .clr(clr), .blink_mask(blink_a),
        .dp_en(dp_en), .dp_pos(dp_pos), .an(an_a), .seg(seg_a), .dp(dp_a)
    );

    sevseg_digit_bank #(.DIGITS(3), .SCAN_CYCLES(S), .BLINK_CYCLES(B)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .shift_mode(shift_mode),
        .wr_pos(wr_pos), .wr_num(wr_num), .clr(clr), .blink_mask(blink_b),
        .dp_en(dp_en), .dp_pos(dp_pos), .an(an_b), .seg(seg_b), .dp(dp_b)
    );

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
            4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
            8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
           12: return 7'h46;  13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, act, exp, n);
        end
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) begin
                mval[d][i] = 0;
                mvld[d][i] = 1'b0;
            end
    endtask

    // One clock: predict outputs from pre-edge model state, apply the write, compare.
    task automatic step(input string tag);
        int idx;
        bit bm;
        bit blank;
        for (int d = 0; d < 2; d++) begin
            idx   = (n / S) % nd[d];
            bm    = (d == 0) ? blink_a[idx] : blink_b[idx];
            blank = !mvld[d][idx] || ((((n / B) % 2) == 1) && bm);
            exp_seg[d] = blank ? 7'h7F : glyph(mval[d][idx]);
            exp_an[d]  = ~(8'd1 << idx);
            exp_dp[d]  = !(dp_en && (int'(dp_pos) == idx));
        end
        for (int d = 0; d < 2; d++) begin
            if (clr) begin
                for (int i = 0; i < 8; i++) begin
                    mval[d][i] = 0;
                    mvld[d][i] = 1'b0;
                end
            end else if (wr_en) begin
                if (shift_mode) begin
                    for (int i = nd[d] - 1; i > 0; i--) begin
                        mval[d][i] = mval[d][i-1];
                        mvld[d][i] = mvld[d][i-1];
                    end
                    mval[d][0] = int'(wr_num);
                    mvld[d][0] = 1'b1;
                end else if (int'(wr_pos) < nd[d]) begin
                    mval[d][int'(wr_pos)] = int'(wr_num);
                    mvld[d][int'(wr_pos)] = 1'b1;
                end
            end
        end
        n++;
        @(posedge clk);
        #1;
        check({tag, "/an_a"},  {4'b0, an_a},  {4'b0, exp_an[0][3:0]});
        check({tag, "/seg_a"}, {1'b0, seg_a}, {1'b0, exp_seg[0]});
        check({tag, "/dp_a"},  {7'b0, dp_a},  {7'b0, exp_dp[0]});
        check({tag, "/an_b"},  {5'b0, an_b},  {5'b0, exp_an[1][2:0]});
        check({tag, "/seg_b"}, {1'b0, seg_b}, {1'b0, exp_seg[1]});
        check({tag, "/dp_b"},  {7'b0, dp_b},  {7'b0, exp_dp[1]});
        @(negedge clk);
    endtask

    task automatic idle(input int k, input string tag);
        for (int i = 0; i < k; i++) step(tag);
    endtask

    task automatic wr(input logic sm, input logic [1:0] pos, input logic [3:0] num, input string tag);
        wr_en      = 1'b1;
        shift_mode = sm;
        wr_pos     = pos;
        wr_num     = num;
        step(tag);
        wr_en = 1'b0;
    endtask

    // Asynchronous assertion is checked before any clock edge arrives.
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "/an_a"},  {4'b0, an_a},  8'h0F);
        check({tag, "/seg_a"}, {1'b0, seg_a}, 8'h7F);
        check({tag, "/dp_a"},  {7'b0, dp_a},  8'h01);
        check({tag, "/an_b"},  {5'b0, an_b},  8'h07);
        check({tag, "/seg_b"}, {1'b0, seg_b}, 8'h7F);
        check({tag, "/dp_b"},  {7'b0, dp_b},  8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        model_clear();
    endtask

    initial begin
        rst_n = 1'b1; wr_en = 1'b0; shift_mode = 1'b0; clr = 1'b0; dp_en = 1'b0;
        wr_pos = '0; dp_pos = '0; wr_num = '0; blink_a = '0; blink_b = '0;
        n = 0;
        model_clear();
        @(negedge clk);
        pulse_reset("reset");

        idle(20, "scan_idle");

        wr(1'b0, 2'd0, 4'h1, "pos_w0");
        wr(1'b0, 2'd2, 4'h8, "pos_w2");
        wr(1'b0, 2'd3, 4'hA, "pos_w3");
        idle(16, "pos_show");

        clr = 1'b1; step("clr"); clr = 1'b0;
        for (int v = 1; v <= 5; v++) wr(1'b1, 2'd0, 4'(v), "shift_w");
        idle(16, "shift_show");

        clr = 1'b1; wr(1'b1, 2'd0, 4'h7, "clr_wr"); clr = 1'b0;
        idle(6, "clr_show");

        wr(1'b0, 2'd1, 4'h8, "blink_w1");
        wr(1'b0, 2'd0, 4'h3, "blink_w0");
        blink_a = 4'b0010;
        blink_b = 3'b010;
        idle(40, "blink");
        blink_a = '0;
        blink_b = '0;

        dp_en = 1'b1;
        dp_pos = 2'd2;
        idle(20, "dp");
        dp_pos = 2'd3;
        idle(12, "dp3");

        for (int i = 0; i < 400; i++) begin
            wr_en      = 1'($urandom_range(0, 1));
            shift_mode = 1'($urandom_range(0, 1));
            wr_pos     = 2'($urandom_range(0, 3));
            wr_num     = 4'($urandom);
            clr        = ($urandom_range(0, 24) == 0);
            blink_a    = 4'($urandom);
            blink_b    = 3'($urandom);
            dp_en      = 1'($urandom_range(0, 1));
            dp_pos     = 2'($urandom_range(0, 3));
            step("rand");
            if (i == 200) begin
                wr_en = 1'b0;
                clr   = 1'b0;
                pulse_reset("rand_reset");
            end
        end
        wr_en = 1'b0; clr = 1'b0; blink_a = '0; blink_b = '0; dp_en = 1'b1; dp_pos = 2'd0;

        wr(1'b0, 2'd1, 4'h5, "pre_rst_w");
        idle(5, "pre_rst");
        pulse_reset("mid_reset");
        idle(10, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sevseg_digit_bank.md
# sevseg_digit_bank

Parametrised N-digit seven-segment display controller: a bank of DIGITS 4-bit digit registers with per-digit blanking, written either by position or by calculator-style shift entry. It includes its own time-multiplexed anode scan, per-digit blink and decimal-point control. It sits between switch/button input logic and the board's anode/segment pins, replacing the fixed four-register loader plus separate 4-digit driver.

## Interface

- DIGITS, 4: number of digits/anodes, 2..8
- SCAN_CYCLES, 100000: clk cycles each digit is driven, ≥ 2
- BLINK_CYCLES, 25000000: clk cycles per blink half-period, ≥ 2
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe, one write per cycle it is high
- shift_mode  in  1  0: positional write; 1: shift-in write
- wr_pos  in  $clog2(DIGITS)  target digit for positional write
- wr_num  in  4  hex value to write
- clr  in  1  blank all digits
- blink_mask  in  DIGITS  bit i=1: digit i blinks
- dp_en  in  1  enable decimal point
- dp_pos  in  $clog2(DIGITS)  digit carrying the decimal point
- an  out  DIGITS  anodes, active-low, one-hot-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

## Operation

- Storage: per digit, a 4-bit value and a valid bit. Invalid digits are blank (seg = 7'h7F).
- Priority: clr > wr_en. clr sets every value to 0 and every valid bit to 0.
- Positional write (wr_en, shift_mode=0): digit[wr_pos] ← wr_num, valid=1. wr_pos ≥ DIGITS: write ignored, no state change.
- Shift write (wr_en, shift_mode=1): digit[i] ← digit[i-1] for i = DIGITS-1..1, including valid bits. digit[0] ← wr_num with valid=1. The old digit[DIGITS-1] is discarded.
- Scan counter: runs 0..SCAN_CYCLES-1. On wrap, the scan index advances 0→1→…→DIGITS-1→0.
- Blink counter: runs 0..BLINK_CYCLES-1. On wrap, the blink phase toggles. While phase=1, digit i is blanked if blink_mask[i]=1.
- Decode, hex 0..F, standard glyphs: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, A=7'b0001000, F=7'b0001110.
- dp = 0 only when dp_en=1 and dp_pos equals the scan index. dp is not blanked by blink or by an invalid digit.

## Timing

- Reset (async assert, sync effect on release): all values 0, all valid 0; scan index 0, both counters 0, blink phase 0; an = all ones, seg = 7'h7F, dp = 1.
- Writes and clr take effect on the rising edge where they are sampled.
- an, seg and dp are registered together from the current scan index and storage, so they never mismatch.
- Display latency: a write at edge k appears on seg at edge k+1 if that digit is selected.
- First edge after reset release: an = ~1 (digit 0), seg blank.
- Scan index changes at edge n·SCAN_CYCLES. Outputs follow at the next edge.
- A write to the currently displayed digit updates seg mid-slot, without waiting for the next scan.
- Changes to blink_mask, dp_en and dp_pos are visible one edge later.
- rst_n asserted mid-operation: all state returns to reset values immediately.

## Structure

- Package sevseg_pkg holds:
  - seg_t (logic [6:0])
  - SEG_BLANK = 7'h7F
  - glyph constants for 0..F
- One combinational sub-module, sevseg_hex_decode: 4-bit value plus blank flag in, seg_t out.
- Top level holds storage, the write/shift logic, both counters and the output registers.

## Test plan

- Reset, then DIGITS=4, SCAN_CYCLES=4, no writes: an cycles 1110→1101→1011→0111 every 4 clocks; seg stays 7'h7F.
- Positional writes 1@0, 8@2; wr_pos=3 with value A: seg shows 7'b1111001, 7'h7F, 7'b0000000, 7'b0001000 in scan order. A write with wr_pos ≥ DIGITS (DIGITS=3) changes nothing.
- Shift writes 1,2,3,4,5 (DIGITS=4): digits 3..0 read 2,3,4,5, and the 1 is discarded. clr and wr_en in the same cycle: all blank.
- BLINK_CYCLES=8, blink_mask=4'b0010, digit 1 = 8: digit 1 alternates 7'b0000000 / 7'h7F every 8 clocks; the other digits are steady.
- dp_en=1, dp_pos=2: dp=0 only while an=1011, including when digit 2 is invalid.
- rst_n pulsed low mid-scan after writes: an=all ones, seg=7'h7F and dp=1 at once; after release, digit 0 is shown blank.
